// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write register file with per-register pending-write scoreboard.
// Define REGFILE_WRITE_BYPASS_EN for same-cycle write-to-read forwarding on both read ports.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    input  logic              RES_EN,
    input  logic [ADDR_W-1:0] RES_A,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              BUSY1,
    output logic              BUSY2,
    output logic              ANY_BUSY
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR = ZERO_REG != 0;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_n;
    logic              any_busy;
    logic              wr_ok;
    logic              res_ok;
    logic              z1;
    logic              z2;
    logic              byp1;
    logic              byp2;

    assign wr_ok  = WE3 && !(ZR && a3 == '0);
    assign res_ok = RES_EN && !(ZR && RES_A == '0);

    // The reservation is applied after the write-clear so a new producer wins on a collision.
    always_comb begin
        busy_n = busy;
        if (wr_ok) busy_n[a3] = 1'b0;
        if (res_ok) busy_n[RES_A] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= '0;
            any_busy <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            busy     <= busy_n;
            any_busy <= |busy_n;
            if (wr_ok) regs[a3] <= WD3;
        end
    end

    assign z1 = ZR && a1 == '0;
    assign z2 = ZR && a2 == '0;

`ifdef REGFILE_WRITE_BYPASS_EN
    assign byp1 = wr_ok && a3 == a1;
    assign byp2 = wr_ok && a3 == a2;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign RD1      = z1 ? '0 : byp1 ? WD3 : regs[a1];
    assign RD2      = z2 ? '0 : byp2 ? WD3 : regs[a2];
    assign BUSY1    = !z1 && !byp1 && busy[a1];
    assign BUSY2    = !z2 && !byp2 && busy[a2];
    assign ANY_BUSY = any_busy;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed plan plus randomized traffic checked against an array-based model.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a1, a2, a3, res_a;
    logic [31:0] wd3;
    logic        we3, res_en;
    logic [31:0] rd1, rd2;
    logic        busy1, busy2, any_busy;

    int total = 0;
    int bad = 0;

    logic [31:0] m_reg [32];
    bit          m_busy [32];
    bit          valid = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .WD3(wd3), .WE3(we3),
        .RES_EN(res_en), .RES_A(res_a), .RD1(rd1), .RD2(rd2), .BUSY1(busy1),
        .BUSY2(busy2), .ANY_BUSY(any_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (we3 && a3 == a) return wd3;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (we3 && a3 == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic exp_any();
        for (int i = 0; i < 32; i++) if (m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare();
        chk("RD1", rd1, exp_rd(a1));
        chk("RD2", rd2, exp_rd(a2));
        chk("BUSY1", 32'(busy1), 32'(exp_busy(a1)));
        chk("BUSY2", 32'(busy2), 32'(exp_busy(a2)));
        chk("ANY_BUSY", 32'(any_busy), 32'(exp_any()));
    endtask

    // Advance one edge (model follows the inputs that were held), then apply new inputs and check.
    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic re, input logic [4:0] ra,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 0;
                m_busy[i] = 0;
            end
            valid = 1;
        end else begin
            if (we3 && a3 != 0) begin
                m_reg[a3] = wd3;
                m_busy[a3] = 0;
            end
            if (res_en && res_a != 0) m_busy[res_a] = 1;
        end
        @(negedge clk);
        reset = rst; we3 = we; a3 = wa; wd3 = wd; res_en = re; res_a = ra; a1 = r1; a2 = r2;
        #1;
        if (valid) compare();
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        drive(0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        reset = 1; we3 = 0; a3 = 0; wd3 = 0; res_en = 0; res_a = 0; a1 = 0; a2 = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        // Reset and scan every address
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_any", 32'(any_busy), 32'h0);
        // Plain write, then write to r0
        drive(0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0);
        idle(7, 0);
        chk("wr7_rd1", rd1, 32'hDEADBEEF);
        drive(0, 1, 0, 32'h1234, 0, 0, 0, 0);
        idle(7, 0);
        chk("r0_rd2", rd2, 32'h0);
        // Reserve then complete
        drive(0, 0, 0, 0, 1, 9, 0, 0);
        idle(9, 0);
        chk("res9_busy1", 32'(busy1), 32'h1);
        chk("res9_any", 32'(any_busy), 32'h1);
        drive(0, 1, 9, 32'h55, 0, 0, 9, 0);
        idle(9, 0);
        chk("wr9_busy1", 32'(busy1), 32'h0);
        chk("wr9_any", 32'(any_busy), 32'h0);
        chk("wr9_rd1", rd1, 32'h55);
        // Reserve and write same register on one edge: new producer stays busy
        drive(0, 0, 0, 0, 1, 4, 0, 0);
        drive(0, 1, 4, 32'hA5, 1, 4, 0, 0);
        idle(4, 0);
        chk("col4_rd1", rd1, 32'hA5);
        chk("col4_busy1", 32'(busy1), 32'h1);
        drive(0, 0, 0, 0, 1, 5, 0, 0);
        drive(0, 1, 5, 32'h1, 1, 3, 0, 0);
        idle(3, 5);
        chk("res3_busy1", 32'(busy1), 32'h1);
        chk("wr5_busy2", 32'(busy2), 32'h0);
        // r0 reservation ignored
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        idle(0, 0);
        chk("res0_busy1", 32'(busy1), 32'h0);
        // Reset beats a concurrent write
        drive(0, 0, 0, 0, 1, 12, 0, 0);
        drive(0, 1, 12, 32'h77, 0, 0, 0, 0);
        drive(1, 1, 12, 32'h99, 0, 0, 0, 0);
        idle(12, 4);
        chk("rst12_rd1", rd1, 32'h0);
        chk("rst12_busy1", 32'(busy1), 32'h0);
        chk("rst12_any", 32'(any_busy), 32'h0);
        // Same-cycle write/read
        drive(0, 1, 6, 32'h10, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 6, 0, 0);
        drive(0, 1, 6, 32'h20, 0, 0, 6, 0);
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("byp_rd1", rd1, 32'h20);
        chk("byp_busy1", 32'(busy1), 32'h0);
`else
        chk("nobyp_rd1", rd1, 32'h10);
        chk("nobyp_busy1", 32'(busy1), 32'h1);
`endif
        idle(6, 0);
        chk("after_rd1", rd1, 32'h20);
        // Randomized traffic on a narrowed address range to force collisions
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] hi;
            hi = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
            drive($urandom_range(0, 63) == 0, 1'($urandom), 5'($urandom_range(0, hi)), $urandom,
                  1'($urandom), 5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)),
                  5'($urandom_range(0, hi)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
